instruction_prefetch_queue: RTL

//  Parametrised successor fetch stage: streams sequential instruction requests over the syn/ack bus into a DEPTH-entry prefetch FIFO.

---
 rtl/instruction_prefetch_queue.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instruction_prefetch_queue
// Purpose  : Sequential instruction prefetch stage. Issues one outstanding
//            request at a time on a syn/ack bus and stores responses in a
//            DEPTH-entry show-ahead FIFO. A redirect (f_change_pc) flushes
//            the FIFO and squashes any response still in flight.
// Ports    : f_clk/f_rst           clock, asynchronous active-high reset
//            f_i_ce                fetch enable (gates new requests only)
//            f_o_syn/f_o_addr_instr request valid / address (held until ack)
//            f_i_ack/f_i_instr     response valid / data
//            f_i_last              response marks end of program -> halt
//            f_change_pc/f_alu_pc_value  redirect strobe / target
//            f_o_ce/f_o_instr/f_pc head valid / instruction / its address
//            f_i_stall             downstream hold (no dequeue)
//            f_o_count/f_o_halted  FIFO occupancy / halted-by-last flag
// Revision : 1.0  initial release
// ============================================================================
module instruction_prefetch_queue #(
  parameter int                IWIDTH   = 32,
  parameter int                PC_WIDTH = 32,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         f_clk,
  input  logic                         f_rst,
  input  logic                         f_i_ce,
  output logic                         f_o_syn,
  output logic [PC_WIDTH-1:0]          f_o_addr_instr,
  input  logic                         f_i_ack,
  input  logic [IWIDTH-1:0]            f_i_instr,
  input  logic                         f_i_last,
  input  logic                         f_change_pc,
  input  logic [PC_WIDTH-1:0]          f_alu_pc_value,
  output logic                         f_o_ce,
  output logic [IWIDTH-1:0]            f_o_instr,
  output logic [PC_WIDTH-1:0]          f_pc,
  input  logic                         f_i_stall,
  output logic [$clog2(DEPTH+1)-1:0]   f_o_count,
  output logic                         f_o_halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [CNT_W-1:0]    C_DEPTH = CNT_W'(DEPTH);
  localparam logic [PC_WIDTH-1:0] C_STEP  = PC_WIDTH'(PC_STEP);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  // Fetch control state
  logic [1:0]          r_state;
  logic                r_syn;
  logic [PC_WIDTH-1:0] r_addr;
  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic                r_drop;
  logic                r_halted;

  // FIFO storage
  logic [IWIDTH-1:0]   r_mem_instr [DEPTH];
  logic [PC_WIDTH-1:0] r_mem_pc    [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_deq;
  logic                w_ack;
  logic                w_push;
  logic [CNT_W-1:0]    w_count_next;
  logic                w_issue_idle;
  logic                w_issue_next;
  logic [PC_WIDTH-1:0] w_pc_inc;

  assign w_deq  = (r_count != '0) && !f_i_stall;
  assign w_ack  = (r_state == S_REQ) && f_i_ack;
  // A squashed response (drop pending, or redirect at the same edge) is never stored.
  assign w_push = w_ack && !r_drop && !f_change_pc;

  assign w_count_next = r_count + {{(CNT_W-1){1'b0}}, w_push}
                                - {{(CNT_W-1){1'b0}}, w_deq};

  // From IDLE the decision uses current occupancy; on an ack it uses the
  // occupancy after this edge's push/pop so back-to-back issue can never
  // overrun the FIFO.
  assign w_issue_idle = f_i_ce && (r_count < C_DEPTH);
  assign w_issue_next = f_i_ce && (w_count_next < C_DEPTH);
  assign w_pc_inc     = r_fetch_pc + C_STEP;

  // --------------------------------------------------------------------------
  // FIFO: redirect clears it and suppresses that edge's enqueue/dequeue.
  // --------------------------------------------------------------------------
  always_ff @(posedge f_clk or posedge f_rst) begin
    if (f_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
      end
    end else if (f_change_pc) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem_instr[r_wptr] <= f_i_instr;
        r_mem_pc[r_wptr]    <= r_addr;
        r_wptr              <= r_wptr + 1'b1;
      end
      if (w_deq) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_next;
    end
  end

  // --------------------------------------------------------------------------
  // Request FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge f_clk or posedge f_rst) begin
    if (f_rst) begin
      r_state    <= S_IDLE;
      r_syn      <= 1'b0;
      r_addr     <= '0;
      r_fetch_pc <= RESET_PC;
      r_drop     <= 1'b0;
      r_halted   <= 1'b0;
    end else if (f_change_pc) begin
      r_fetch_pc <= f_alu_pc_value;
      r_halted   <= 1'b0;
      case (r_state)
        S_REQ: begin
          if (f_i_ack) begin
            // Response arrives with the redirect: discard it and restart
            // from the new target on a later cycle.
            r_syn   <= 1'b0;
            r_drop  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            // Old request stays on the bus; its response will be discarded.
            r_drop <= 1'b1;
          end
        end
        S_HALT:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue_idle) begin
            r_syn      <= 1'b1;
            r_addr     <= r_fetch_pc;
            r_fetch_pc <= w_pc_inc;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (f_i_ack) begin
            if (!r_drop && f_i_last) begin
              r_syn    <= 1'b0;
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_drop <= 1'b0;
              if (w_issue_next) begin
                r_addr     <= r_fetch_pc;
                r_fetch_pc <= w_pc_inc;
              end else begin
                r_syn   <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
        end
        S_HALT: begin
        end
        default: begin
          r_syn   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign f_o_syn        = r_syn;
  assign f_o_addr_instr = r_addr;
  assign f_o_ce         = (r_count != '0);
  assign f_o_instr      = r_mem_instr[r_rptr];
  assign f_pc           = r_mem_pc[r_rptr];
  assign f_o_count      = r_count;
  assign f_o_halted     = r_halted;

endmodule
`default_nettype wire
